// File: rtl/mux_cond_4to1.sv
// mux_cond_4to1: parameterised N:1 conditional-operator mux with a combinational and a registered output.
// Optional registered select-range flag (sel_err) when MUX_COND_SEL_ERR_EN is defined.
module mux_cond_4to1 #(
    parameter int NUM_IN = 4,
    parameter int WIDTH  = 1,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in,
    input  logic                    en,
    output logic [WIDTH-1:0]        out,
    output logic [WIDTH-1:0]        out_q,
    output logic [SEL_W-1:0]        sel_q
`ifdef MUX_COND_SEL_ERR_EN
    ,
    output logic                    sel_err
`endif
);
    localparam int LEAVES = 1 << SEL_W;

    if (NUM_IN < 2 || NUM_IN > 16 || LEAVES < NUM_IN) begin : g_bad_cfg
        $error("mux_cond_4to1: illegal NUM_IN/SEL_W combination");
    end

    // Binary tree, one level per select bit, MSB at the root; unused leaves read as zero.
    for (genvar d = 0; d <= SEL_W; d++) begin : g_lvl
        logic [WIDTH-1:0] lv [1 << d];
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            if (d == SEL_W) begin : g_leaf
                if (j < NUM_IN) begin : g_in
                    assign lv[j] = in[j*WIDTH +: WIDTH];
                end else begin : g_pad
                    assign lv[j] = '0;
                end
            end else begin : g_mux
                assign lv[j] = sel[SEL_W-1-d] ? g_lvl[d+1].lv[2*j+1] : g_lvl[d+1].lv[2*j];
            end
        end
    end

    // An unknown select must not masquerade as a valid pick when both branches agree.
    assign out = (^sel === 1'bx) ? {WIDTH{1'bx}} : g_lvl[0].lv[0];

    logic [WIDTH-1:0] out_d;
    logic [SEL_W-1:0] sel_d;

    always_comb begin
        out_d = en ? out : out_q;
        sel_d = en ? sel : sel_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            sel_q <= '0;
        end else begin
            out_q <= out_d;
            sel_q <= sel_d;
        end
    end

`ifdef MUX_COND_SEL_ERR_EN
    if (LEAVES == NUM_IN) begin : g_err_none
        assign sel_err = 1'b0;
    end else begin : g_err
        localparam logic [SEL_W:0] LIMIT = NUM_IN[SEL_W:0];
        logic sel_err_d;
        always_comb sel_err_d = ({1'b0, sel} >= LIMIT);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sel_err <= 1'b0;
            else sel_err <= sel_err_d;
        end
    end
`endif
endmodule

// File: tb/tb_mux_cond_4to1.sv
// tb_mux_cond_4to1: randomized self-checking bench for mux_cond_4to1 (4:1x1 and 3:1x4 instances).
module tb_mux_cond_4to1;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  sel_a = '0;
    logic [3:0]  in_a = '0;
    logic        out_a, out_q_a;
    logic [1:0]  sel_q_a;
    logic [1:0]  sel_b = '0;
    logic [11:0] in_b = '0;
    logic [3:0]  out_b, out_q_b;
    logic [1:0]  sel_q_b;
`ifdef MUX_COND_SEL_ERR_EN
    logic        sel_err_a, sel_err_b;
`endif
    logic        m_qa = 1'b0, m_err = 1'b0;
    logic [1:0]  m_sa = '0, m_sb = '0;
    logic [3:0]  m_qb = '0;
    int pass = 0, total = 0;

    always #5 clk = ~clk;

    mux_cond_4to1 #(.NUM_IN(4), .WIDTH(1), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .sel(sel_a), .in(in_a), .en(en),
        .out(out_a), .out_q(out_q_a), .sel_q(sel_q_a)
`ifdef MUX_COND_SEL_ERR_EN
        , .sel_err(sel_err_a)
`endif
    );

    mux_cond_4to1 #(.NUM_IN(3), .WIDTH(4), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel_b), .in(in_b), .en(en),
        .out(out_b), .out_q(out_q_b), .sel_q(sel_q_b)
`ifdef MUX_COND_SEL_ERR_EN
        , .sel_err(sel_err_b)
`endif
    );

    function automatic logic [15:0] ref_mux(int n, int w, logic [63:0] v, int s);
        return (s < n) ? 16'((v >> (s * w)) & ((64'd1 << w) - 64'd1)) : 16'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            m_err = (sel_b >= 2'd3);
            if (en) begin
                m_qa = 1'(ref_mux(4, 1, 64'(in_a), int'(sel_a)));
                m_sa = sel_a;
                m_qb = 4'(ref_mux(3, 4, 64'(in_b), int'(sel_b)));
                m_sb = sel_b;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        total++; if (out_q_a !== 1'b0) $display("FAIL reset_out_q_a got %b exp 0", out_q_a); else pass++;
        total++; if (sel_q_a !== 2'b00) $display("FAIL reset_sel_q_a got %b exp 00", sel_q_a); else pass++;
        total++; if (out_q_b !== 4'h0) $display("FAIL reset_out_q_b got %h exp 0", out_q_b); else pass++;
        total++; if (sel_q_b !== 2'b00) $display("FAIL reset_sel_q_b got %b exp 00", sel_q_b); else pass++;
        en = 1'b1; in_a = 4'b1011; sel_a = 2'd3;
        tick();
        total++; if (out_q_a !== 1'b0) $display("FAIL reset_hold_out_q got %b exp 0", out_q_a); else pass++;
        total++; if (out_a !== 1'b1) $display("FAIL reset_comb_out got %b exp 1", out_a); else pass++;
        rst_n = 1'b1; en = 1'b0;
    endtask

    task automatic test_comb();
        logic exp_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        in_a = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            #5;
            total++; if (out_a !== exp_tab[s]) $display("FAIL comb_sel%0d got %b exp %b", s, out_a, exp_tab[s]); else pass++;
        end
    endtask

    task automatic test_follow();
        logic [3:0] pat [6] = '{4'b0000, 4'b0100, 4'b0000, 4'b1011, 4'b1111, 4'b0100};
        sel_a = 2'd2;
        foreach (pat[i]) begin
            in_a = pat[i];
            #2;
            total++; if (out_a !== pat[i][2]) $display("FAIL follow_in%0d got %b exp %b", i, out_a, pat[i][2]); else pass++;
        end
    endtask

    task automatic test_pipeline();
        logic exp_tab [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        en = 1'b1; in_a = 4'b1011;
        for (int s = 0; s < 4; s++) begin
            sel_a = 2'(s);
            tick();
            total++; if (out_q_a !== exp_tab[s]) $display("FAIL pipe_out_q%0d got %b exp %b", s, out_q_a, exp_tab[s]); else pass++;
            total++; if (sel_q_a !== 2'(s)) $display("FAIL pipe_sel_q%0d got %0d exp %0d", s, sel_q_a, s); else pass++;
        end
    endtask

    task automatic test_hold();
        en = 1'b1; in_a = 4'b1011; sel_a = 2'd3;
        tick();
        en = 1'b0; sel_a = 2'd2;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++; if (out_q_a !== 1'b1) $display("FAIL hold_out_q%0d got %b exp 1", k, out_q_a); else pass++;
            total++; if (sel_q_a !== 2'd3) $display("FAIL hold_sel_q%0d got %0d exp 3", k, sel_q_a); else pass++;
            total++; if (out_a !== 1'b0) $display("FAIL hold_out%0d got %b exp 0", k, out_a); else pass++;
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; sel_a = 2'd3; in_b = 12'h5a3; sel_b = 2'd1;
        tick();
        #2 rst_n = 1'b0;
        m_qa = 1'b0; m_sa = '0; m_qb = '0; m_sb = '0; m_err = 1'b0;
        #1;
        total++; if (out_q_a !== 1'b0) $display("FAIL areset_out_q got %b exp 0", out_q_a); else pass++;
        total++; if (sel_q_a !== 2'd0) $display("FAIL areset_sel_q got %0d exp 0", sel_q_a); else pass++;
        total++; if (out_q_b !== 4'h0) $display("FAIL areset_out_q_b got %h exp 0", out_q_b); else pass++;
        total++; if (out_a !== 1'b1) $display("FAIL areset_out got %b exp 1", out_a); else pass++;
        total++; if (out_b !== 4'ha) $display("FAIL areset_out_b got %h exp a", out_b); else pass++;
        #1 rst_n = 1'b1;
        tick();
        total++; if (out_q_a !== 1'b1) $display("FAIL release_out_q got %b exp 1", out_q_a); else pass++;
        total++; if (sel_q_a !== 2'd3) $display("FAIL release_sel_q got %0d exp 3", sel_q_a); else pass++;
    endtask

    task automatic test_out_of_range();
        en = 1'b1; in_b = 12'h7c5; sel_b = 2'd3;
        #1;
        total++; if (out_b !== 4'h0) $display("FAIL oor_out got %h exp 0", out_b); else pass++;
        tick();
`ifdef MUX_COND_SEL_ERR_EN
        total++; if (sel_err_b !== 1'b1) $display("FAIL oor_sel_err got %b exp 1", sel_err_b); else pass++;
        total++; if (sel_err_a !== 1'b0) $display("FAIL pow2_sel_err got %b exp 0", sel_err_a); else pass++;
`endif
        total++; if (out_q_b !== 4'h0) $display("FAIL oor_out_q got %h exp 0", out_q_b); else pass++;
        sel_b = 2'd1;
        #1;
        total++; if (out_b !== 4'hc) $display("FAIL inrange_out got %h exp c", out_b); else pass++;
        tick();
`ifdef MUX_COND_SEL_ERR_EN
        total++; if (sel_err_b !== 1'b0) $display("FAIL inrange_sel_err got %b exp 0", sel_err_b); else pass++;
`endif
        total++; if (out_q_b !== 4'hc) $display("FAIL inrange_out_q got %h exp c", out_q_b); else pass++;
    endtask

    task automatic test_random();
        logic [3:0] ea, eb;
        for (int i = 0; i < 150; i++) begin
            sel_a = 2'($urandom); in_a = 4'($urandom);
            sel_b = 2'($urandom); in_b = 12'($urandom);
            en = 1'($urandom_range(0, 3) != 0);
            #1;
            ea = 4'(ref_mux(4, 1, 64'(in_a), int'(sel_a)));
            eb = 4'(ref_mux(3, 4, 64'(in_b), int'(sel_b)));
            total++; if (out_a !== ea[0]) $display("FAIL rnd_out_a i=%0d got %b exp %b", i, out_a, ea[0]); else pass++;
            total++; if (out_b !== eb) $display("FAIL rnd_out_b i=%0d got %h exp %h", i, out_b, eb); else pass++;
            tick();
            total++; if ({out_q_a, sel_q_a} !== {m_qa, m_sa}) $display("FAIL rnd_reg_a i=%0d got %b/%0d exp %b/%0d", i, out_q_a, sel_q_a, m_qa, m_sa); else pass++;
            total++; if ({out_q_b, sel_q_b} !== {m_qb, m_sb}) $display("FAIL rnd_reg_b i=%0d got %h/%0d exp %h/%0d", i, out_q_b, sel_q_b, m_qb, m_sb); else pass++;
`ifdef MUX_COND_SEL_ERR_EN
            total++; if (sel_err_b !== m_err) $display("FAIL rnd_sel_err i=%0d got %b exp %b", i, sel_err_b, m_err); else pass++;
`endif
        end
    endtask

    initial begin
        test_reset();
        test_comb();
        test_follow();
        test_pipeline();
        test_hold();
        test_async_reset();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
